// File: rtl/frog_round_ctrl.sv
// Round controller for the frog-crossing game: turns button edges into move
// pulses, detects wins and hits, tracks score and lives, and paces the pauses.
module frog_round_ctrl #(
    parameter int LIVES        = 3,
    parameter int PAUSE_CYCLES = 4,
    parameter int SCORE_MAX    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [2:0] row_number,
    input  logic       car_hit,
    output logic       U,
    output logic       D,
    output logic       winResult,
    output logic       loseResult,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        WIN      = 3'd2,
        LOSE     = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [2:0] PAUSE_LOAD = 3'(PAUSE_CYCLES - 1);
    localparam logic [3:0] SCORE_CAP  = 4'(SCORE_MAX);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= SCORE_CAP) begin
            sat_inc = SCORE_CAP;
        end else begin
            sat_inc = v + 4'd1;
        end
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [2:0] pause_r;
    logic [2:0] pause_s;
    logic       prev_up;
    logic       prev_down;
    logic       rise_up_s;
    logic       rise_down_s;
    logic       u_s;
    logic       d_s;
    logic       win_s;
    logic       lose_s;
    logic [3:0] score_s;
    logic [1:0] lives_s;

    assign rise_up_s   = key_up & ~prev_up;
    assign rise_down_s = key_down & ~prev_down;

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            pause_r    <= 3'd0;
            prev_up    <= 1'b0;
            prev_down  <= 1'b0;
            U          <= 1'b0;
            D          <= 1'b0;
            winResult  <= 1'b0;
            loseResult <= 1'b0;
            score      <= 4'd0;
            lives      <= LIVES_INIT;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_r    <= state_s;
            pause_r    <= pause_s;
            prev_up    <= key_up;
            prev_down  <= key_down;
            U          <= u_s;
            D          <= d_s;
            winResult  <= win_s;
            loseResult <= lose_s;
            score      <= score_s;
            lives      <= lives_s;
            playing    <= (state_s == PLAY);
            game_over  <= (state_s == GAMEOVER);
        end
    end

    // Next-state selection; a hit outranks reaching the home row.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, GAMEOVER: begin
                if (start) begin
                    state_s = PLAY;
                end else begin
                    state_s = state_r;
                end
            end
            PLAY: begin
                if (car_hit) begin
                    if (lives <= 2'd1) begin
                        state_s = GAMEOVER;
                    end else begin
                        state_s = LOSE;
                    end
                end else if (row_number == 3'd0) begin
                    state_s = WIN;
                end else begin
                    state_s = PLAY;
                end
            end
            WIN, LOSE: begin
                if (pause_r == 3'd0) begin
                    state_s = PLAY;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of pulses, score, lives and the pause counter.
    always_comb begin
        u_s     = 1'b0;
        d_s     = 1'b0;
        win_s   = 1'b0;
        lose_s  = 1'b0;
        score_s = score;
        lives_s = lives;
        pause_s = pause_r;
        case (state_r)
            IDLE, GAMEOVER: begin
                if (start) begin
                    score_s = 4'd0;
                    lives_s = LIVES_INIT;
                end else begin
                    score_s = score;
                    lives_s = lives;
                end
            end
            PLAY: begin
                if (car_hit) begin
                    lose_s  = 1'b1;
                    lives_s = lives - 2'd1;
                    pause_s = PAUSE_LOAD;
                end else if (row_number == 3'd0) begin
                    win_s   = 1'b1;
                    score_s = sat_inc(score);
                    pause_s = PAUSE_LOAD;
                end else begin
                    u_s = rise_up_s & ~rise_down_s;
                    d_s = rise_down_s & ~rise_up_s;
                end
            end
            WIN, LOSE: begin
                if (pause_r != 3'd0) begin
                    pause_s = pause_r - 3'd1;
                end else begin
                    pause_s = 3'd0;
                end
            end
            default: pause_s = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Bench for frog_round_ctrl: directed game scenarios with literal expectations,
// then random play, all tracked cycle by cycle by a behavioural game model.
module tb_frog_round_ctrl;

    localparam int LIVES = 3;
    localparam int PAUSE_CYCLES = 4;
    localparam int SCORE_MAX = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic [2:0] row_number = 3'd7;
    logic       car_hit = 1'b0;
    logic       U, D, winResult, loseResult, playing, game_over;
    logic [3:0] score;
    logic [1:0] lives;

    int checks = 0;
    int failures = 0;

    frog_round_ctrl #(.LIVES(LIVES), .PAUSE_CYCLES(PAUSE_CYCLES), .SCORE_MAX(SCORE_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .key_up(key_up), .key_down(key_down),
        .row_number(row_number), .car_hit(car_hit), .U(U), .D(D), .winResult(winResult),
        .loseResult(loseResult), .score(score), .lives(lives), .playing(playing),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: "where the frog is in the game" plus remaining pause length.
    typedef enum int {M_IDLE, M_PLAY, M_PAUSE, M_OVER} mode_t;
    mode_t m_mode = M_IDLE;
    int m_pause_left = 0;
    int m_score = 0, m_lives = LIVES;
    int m_u = 0, m_d = 0, m_win = 0, m_lose = 0;
    bit m_prev_up = 1'b0, m_prev_down = 1'b0;

    task automatic model_step();
        bit ru, rd;
        ru = key_up && !m_prev_up;
        rd = key_down && !m_prev_down;
        m_u = 0; m_d = 0; m_win = 0; m_lose = 0;
        if (reset) begin
            m_mode = M_IDLE; m_pause_left = 0; m_score = 0; m_lives = LIVES;
            ru = 1'b0; rd = 1'b0;
            m_prev_up = 1'b0; m_prev_down = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE, M_OVER: if (start) begin
                m_mode = M_PLAY; m_score = 0; m_lives = LIVES;
            end
            M_PLAY: begin
                if (car_hit) begin
                    m_lose = 1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_mode = M_OVER;
                    else begin m_mode = M_PAUSE; m_pause_left = PAUSE_CYCLES; end
                end else if (row_number == 3'd0) begin
                    m_win = 1;
                    m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                    m_mode = M_PAUSE; m_pause_left = PAUSE_CYCLES;
                end else begin
                    m_u = (ru && !rd) ? 1 : 0;
                    m_d = (rd && !ru) ? 1 : 0;
                end
            end
            M_PAUSE: begin
                m_pause_left--;
                if (m_pause_left == 0) m_mode = M_PLAY;
            end
            default: m_mode = M_IDLE;
        endcase
        m_prev_up = key_up;
        m_prev_down = key_down;
    endtask

    // Compare process: advance the model on every edge, check the DUT just after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("m_U", int'(U), m_u);
        chk("m_D", int'(D), m_d);
        chk("m_win", int'(winResult), m_win);
        chk("m_lose", int'(loseResult), m_lose);
        chk("m_score", int'(score), m_score);
        chk("m_lives", int'(lives), m_lives);
        chk("m_playing", int'(playing), (m_mode == M_PLAY) ? 1 : 0);
        chk("m_game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    end

    // One clock: drive at negedge, return shortly after the sampling edge.
    task automatic cyc(input bit rst, input bit st, input bit ku, input bit kd,
                       input logic [2:0] row, input bit ch);
        @(negedge clk);
        reset = rst; start = st; key_up = ku; key_down = kd;
        row_number = row; car_hit = ch;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_play(input string name);
        int n;
        n = 0;
        while (!playing && n < 20) begin
            cyc(0, 0, 0, 0, 3'd7, 0);
            n++;
        end
        if (!playing) chk({name, "_timeout"}, 0, 1);
    endtask

    int ucnt, dcnt, pcnt;

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 3'd7, 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_playing", int'(playing), 0);
        chk("rst_U", int'(U), 0);

        // Start, hold key_up for 5 cycles -> exactly one U
        cyc(0, 1, 0, 0, 3'd7, 0);
        chk("start_playing", int'(playing), 1);
        ucnt = 0; dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 3'd6, 0);
            ucnt += int'(U); dcnt += int'(D);
        end
        chk("held_up_U_count", ucnt, 1);
        chk("held_up_D_count", dcnt, 0);

        // Simultaneous rise -> nothing; then key_down alone -> one D
        cyc(0, 0, 0, 0, 3'd6, 0);
        ucnt = 0; dcnt = 0;
        cyc(0, 0, 1, 1, 3'd6, 0);
        ucnt += int'(U); dcnt += int'(D);
        cyc(0, 0, 0, 0, 3'd6, 0);
        ucnt += int'(U); dcnt += int'(D);
        chk("both_U", ucnt, 0);
        chk("both_D", dcnt, 0);
        cyc(0, 0, 0, 1, 3'd6, 0);
        chk("down_D", int'(D), 1);
        chk("down_U", int'(U), 0);
        cyc(0, 0, 0, 1, 3'd6, 0);
        chk("down_held_D", int'(D), 0);

        // Win: one pulse, score 1, exactly 4 non-playing cycles, keys ignored
        cyc(0, 0, 0, 0, 3'd0, 0);
        chk("win_pulse", int'(winResult), 1);
        chk("win_score", int'(score), 1);
        pcnt = 0; ucnt = 0;
        while (!playing && pcnt < 20) begin
            pcnt++;
            cyc(0, 0, pcnt[0], 0, 3'd7, 0);
            ucnt += int'(U) + int'(D) + int'(winResult);
        end
        chk("win_pause_len", pcnt, 4);
        chk("win_pause_moves", ucnt, 0);

        // Hit on home row counts as lose
        cyc(0, 0, 0, 0, 3'd7, 0);
        cyc(0, 0, 0, 0, 3'd0, 1);
        chk("tie_lose", int'(loseResult), 1);
        chk("tie_win", int'(winResult), 0);
        chk("tie_lives", int'(lives), 2);
        chk("tie_score", int'(score), 1);
        wait_play("lose1");
        cyc(0, 0, 0, 0, 3'd5, 1);
        chk("hit2_lives", int'(lives), 1);
        wait_play("lose2");
        cyc(0, 0, 0, 0, 3'd5, 1);
        chk("hit3_lives", int'(lives), 0);
        chk("hit3_over", int'(game_over), 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 3'd0, 1);
        chk("over_hold_lives", int'(lives), 0);
        chk("over_hold_score", int'(score), 1);
        cyc(0, 1, 0, 0, 3'd7, 0);
        chk("restart_playing", int'(playing), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);

        // Ten wins saturate at 9
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 3'd0, 0);
            wait_play("wins");
        end
        chk("sat_score", int'(score), 9);

        // Reset during a win pause
        cyc(0, 0, 0, 0, 3'd0, 0);
        cyc(0, 0, 0, 0, 3'd7, 0);
        cyc(1, 0, 0, 0, 3'd7, 0);
        chk("midpause_rst_score", int'(score), 0);
        chk("midpause_rst_lives", int'(lives), 3);
        chk("midpause_rst_playing", int'(playing), 0);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) == 0),
                ($urandom_range(9) == 0),
                (($urandom_range(2) == 0) ? ~key_up : key_up),
                (($urandom_range(2) == 0) ? ~key_down : key_down),
                (($urandom_range(19) == 0) ? 3'd0 : 3'($urandom_range(7, 1))),
                ($urandom_range(19) == 0));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frog_round_ctrl.md
FROG_ROUND_CTRL -- requirements
Module: frog_round_ctrl

Parameters
REQ-001 The block SHALL have parameter LIVES, default 3, meaning the lives loaded at game start (1..3).
REQ-002 The block SHALL have parameter PAUSE_CYCLES, default 4, meaning the cycles spent in WIN/LOSE before returning to PLAY (1..7).
REQ-003 The block SHALL have parameter SCORE_MAX, default 9, meaning the saturation value of score.

Interface
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; starts a game from IDLE or GAMEOVER.
REQ-007 key_up  input  1  level, already synchronized; up button.
REQ-008 key_down  input  1  level, already synchronized; down button.
REQ-009 row_number  input  3  frog row from the up/down shifter; 0 = home row, 7 = start row.
REQ-010 car_hit  input  1  level; frog currently overlaps a car.
REQ-011 U  output  1  one-cycle move-up pulse to the shifter.
REQ-012 D  output  1  one-cycle move-down pulse to the shifter.
REQ-013 winResult  output  1  one-cycle pulse; frog reached row 0; resets the shifter to row 7.
REQ-014 loseResult  output  1  one-cycle pulse; frog hit; resets the shifter to row 7.
REQ-015 score  output  4  completed crossings, saturating.
REQ-016 lives  output  2  remaining lives.
REQ-017 playing  output  1  high when state = PLAY.
REQ-018 game_over  output  1  high when state = GAMEOVER.

Function
REQ-019 The FSM SHALL have states IDLE, PLAY, WIN, LOSE and GAMEOVER; all outputs SHALL be registered.
REQ-020 IDLE: start=1 -> PLAY, with score<=0 and lives<=LIVES on the same edge.
REQ-021 The block SHALL edge-detect keys with registers prev_up/prev_down, which update every cycle in every state.
- rise_up = key_up & ~prev_up; rise_down likewise.
REQ-022 In PLAY with no win/lose this cycle, U SHALL be 1 on the next cycle iff rise_up & ~rise_down; D SHALL follow the symmetric rule.
- Both rising together -> neither pulse.
- Held keys SHALL never repeat.
REQ-023 U and D SHALL be 0 in every state other than PLAY.
REQ-024 In PLAY, car_hit=1 SHALL produce loseResult=1 for one cycle and lives<=lives-1.
- Next state = GAMEOVER if lives was 1, else LOSE.
REQ-025 In PLAY, row_number=0 with car_hit=0 SHALL produce winResult=1 for one cycle, score<=min(score+1, SCORE_MAX), and next state WIN.
REQ-026 car_hit and row_number=0 in the same cycle SHALL count as a lose; lose has priority.
REQ-027 In a cycle that issues winResult or loseResult, U and D SHALL be 0.
REQ-028 WIN and LOSE SHALL load a 3-bit pause counter with PAUSE_CYCLES-1 on entry and decrement it each cycle; at 0 the FSM SHALL return to PLAY.
- Dwell is exactly PAUSE_CYCLES cycles.
- car_hit and row_number are ignored during the pause.
REQ-029 GAMEOVER: start=1 -> PLAY with score<=0 and lives<=LIVES; otherwise the FSM stays.
- score and lives SHALL hold their final values while waiting.
REQ-030 winResult and loseResult SHALL never be high in consecutive cycles, and never both high in the same cycle.

Reset
REQ-031 reset=1 SHALL, on the next rising edge, set state=IDLE, U=D=winResult=loseResult=0, score=0, lives=LIVES, playing=0, game_over=0, pause counter=0, prev_up=prev_down=0.
REQ-032 Reset SHALL take priority over every other input, including mid-pause and mid-pulse.

Verification
REQ-033 Reset, start=1 for 1 cycle, key_up held high for 5 cycles -> playing=1, exactly one U pulse, D=0 throughout.
REQ-034 In PLAY, key_up and key_down rise on the same edge -> U=D=0; releasing both and then raising key_down alone -> one D pulse.
REQ-035 In PLAY, drive row_number=0 -> one winResult pulse, score 0->1, playing=0 for exactly 4 cycles, then PLAY again; key presses during the pause give no U/D.
REQ-036 In PLAY with lives=3, car_hit and row_number=0 together -> loseResult (not winResult), lives=2, score unchanged.
REQ-037 Three hits (with pauses between) -> lives 3->2->1->0, game_over=1 after the third hit; start=1 -> PLAY, lives=3, score=0.
REQ-038 Ten wins -> score saturates at 9; asserting reset during the WIN pause -> IDLE, score=0, lives=3 one edge later.
